// File: rtl/oven_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Holds the default sizes, the controller state encoding and the digit-adjust rule constants.
package oven_pkg;

   localparam int NDIG_DEFAULT = 4;
   localparam int BW_DEFAULT   = 14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] ADJ_THRESH = 4'd8;
   localparam logic [3:0] ADJ_SUB    = 4'd3;

   // A packed nibble is not a decimal digit when it exceeds 9.
   function automatic logic digit_bad(input logic [3:0] d);
      return (d > 4'd9);
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction step of reverse double-dabble.
// After the right shift, a digit of 8 or more had a 1 shifted into its MSB, so 3 is taken off.
module bcd_digit_adj
   import oven_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] adj
);

   always_comb begin
      adj = digit;
      if (digit >= ADJ_THRESH) begin
         adj = digit - ADJ_SUB;
      end
   end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter using reverse double-dabble.
// One request at a time: IDLE accepts, CONV runs BW shift/adjust iterations, DONE holds the result.
module bcd_to_bin
   import oven_pkg::*;
#(
   parameter int NDIG = NDIG_DEFAULT,
   parameter int BW   = BW_DEFAULT
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4*NDIG-1:0] bcd_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BW-1:0]     bin_out,
   output logic              err
);

   localparam int DW = 4 * NDIG;
   localparam int CW = $clog2(BW + 1);

   state_t          state_reg, state_next;
   logic [DW-1:0]   bcd_reg, bcd_next;
   logic [BW-1:0]   bin_reg, bin_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic            err_reg, err_next;

   logic [DW+BW-1:0] pair_shift;
   logic [DW-1:0]    bcd_adj;
   logic [NDIG-1:0]  bad_digit;

   // The BCD LSB falls into the binary MSB; after BW steps the binary register holds the value.
   assign pair_shift = {bcd_reg, bin_reg} >> 1;

   generate
      for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
         bcd_digit_adj u_adj (
            .digit (pair_shift[BW + 4*gi +: 4]),
            .adj   (bcd_adj[4*gi +: 4])
         );
         assign bad_digit[gi] = digit_bad(bcd_in[4*gi +: 4]);
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         bcd_reg   <= '0;
         bin_reg   <= '0;
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         bcd_reg   <= bcd_next;
         bin_reg   <= bin_next;
         cnt_reg   <= cnt_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      bcd_next   = bcd_reg;
      bin_next   = bin_reg;
      cnt_next   = cnt_reg;
      err_next   = err_reg;

      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               bin_next = '0;
               cnt_next = '0;
               if (|bad_digit) begin
                  // Illegal input skips conversion and reports a zero result.
                  bcd_next   = '0;
                  err_next   = 1'b1;
                  state_next = DONE;
               end else begin
                  bcd_next   = bcd_in;
                  err_next   = 1'b0;
                  state_next = CONV;
               end
            end
         end
         CONV: begin
            bcd_next = bcd_adj;
            bin_next = pair_shift[BW-1:0];
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == CW'(BW - 1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign bin_out   = bin_reg;
   assign err       = err_reg;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: expectations are queued at request time and
// compared when the converter presents its result.
module tb_bcd_to_bin;

   localparam int NDIG = 4;
   localparam int BW   = 14;

   logic              clk;
   logic              reset_n;
   logic              in_valid;
   logic              in_ready;
   logic [4*NDIG-1:0] bcd_in;
   logic              out_valid;
   logic              out_ready;
   logic [BW-1:0]     bin_out;
   logic              err;

   typedef struct {
      logic [15:0] bcd;
      logic [13:0] bin;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   bcd_to_bin #(.NDIG(NDIG), .BW(BW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bcd_in    (bcd_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bin_out   (bin_out),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: decimal weight of each nibble, or an error flag if any nibble exceeds 9.
   function automatic exp_t model(input logic [15:0] b);
      exp_t e;
      int   acc;
      int   w;
      acc   = 0;
      w     = 1;
      e.bcd = b;
      e.err = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (b[4*i +: 4] > 4'd9) e.err = 1'b1;
         acc = acc + int'(b[4*i +: 4]) * w;
         w   = w * 10;
      end
      e.bin = e.err ? 14'd0 : acc[13:0];
      return e;
   endfunction

   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check_value("unexpected_output", 32'(bin_out), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            $display("txn bcd=%04h bin_out=%0d err=%0d (exp %0d/%0d)", e.bcd, bin_out, err, e.bin, e.err);
            check_value("bin_out", 32'(bin_out), 32'(e.bin));
            check_value("err", 32'(err), 32'(e.err));
         end
      end
   end

   task automatic send(input logic [15:0] bcd, input logic keep_valid);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) check_value("ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b1;
      bcd_in   = bcd;
      sb_q.push_back(model(bcd));
      @(posedge clk);
      #1;
      if (!keep_valid) in_valid = 1'b0;
   endtask

   // Counts rising edges after the accepting edge until out_valid is seen.
   task automatic wait_out(input int exp_lat);
      int lat;
      lat = 0;
      forever begin
         @(negedge clk);
         if (out_valid || lat > 100) break;
         @(posedge clk);
         lat++;
      end
      if (!out_valid) check_value("out_timeout", 32'd0, 32'd1);
      check_value("latency", 32'(lat), 32'(exp_lat));
   endtask

   task automatic run_txn(input logic [15:0] bcd);
      exp_t e;
      e = model(bcd);
      send(bcd, 1'b0);
      wait_out(e.err ? 0 : BW);
      @(posedge clk);
      @(negedge clk);
      check_value("in_ready_after", 32'(in_ready), 32'd1);
      check_value("out_valid_after", 32'(out_valid), 32'd0);
   endtask

   task automatic check_reset_state(input string tag);
      check_value({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      check_value({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check_value({tag, "_bin_out"}, 32'(bin_out), 32'd0);
      check_value({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      logic [15:0] v;
      int          seen;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      bcd_in    = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      @(posedge clk);
      #1 reset_n = 1'b1;

      run_txn(16'h0357);
      run_txn(16'h9999);
      run_txn(16'h0000);
      run_txn(16'h12A4);

      for (int n = 0; n < 6; n++) begin
         for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
         run_txn(v);
      end
      for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
      v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      run_txn(v);

      // Backpressure with a different request held on the input throughout.
      out_ready = 1'b0;
      send(16'h0450, 1'b1);
      bcd_in = 16'h0111;
      wait_out(BW);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         @(negedge clk);
         check_value("bp_bin_out", 32'(bin_out), 32'd450);
         check_value("bp_in_ready", 32'(in_ready), 32'd0);
         check_value("bp_out_valid", 32'(out_valid), 32'd1);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check_value("bp_in_ready_after", 32'(in_ready), 32'd1);
      check_value("bp_out_valid_after", 32'(out_valid), 32'd0);

      // Reset in the middle of a conversion abandons it.
      send(16'h0123, 1'b0);
      repeat (7) @(posedge clk);
      #1 reset_n = 1'b0;
      sb_q.delete();
      @(negedge clk);
      check_reset_state("midconv");
      @(posedge clk);
      #1 reset_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check_value("no_valid_after_reset", 32'(seen), 32'd0);
      run_txn(16'h0042);

      repeat (5) @(negedge clk);
      check_value("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

endmodule
